// File: rtl/vm_pkg.sv
// Shared definitions for the multi-product vending machine: coin codes,
// coin-to-unit conversion and FSM state encodings.
package vm_pkg;

  typedef enum logic [1:0] {
    COIN_NONE = 2'd0,
    COIN_5    = 2'd1,
    COIN_10   = 2'd2,
    COIN_20   = 2'd3
  } coin_t;

  typedef enum logic {
    ST_ACCEPT = 1'b0,
    ST_CHANGE = 1'b1
  } state_t;

  // Value of a coin code in units of 5.
  function automatic logic [2:0] coin_units(input logic [1:0] code);
    case (code)
      COIN_5:  return 3'd1;
      COIN_10: return 3'd2;
      COIN_20: return 3'd4;
      default: return 3'd0;
    endcase
  endfunction

endpackage

// File: rtl/vm_change_dispenser.sv
// Greedy change emitter: loads an amount in units and pays it out one coin
// per cycle, largest coin first. The first coin appears in the cycle right
// after the load, so change lines up with the dispense pulse.
module vm_change_dispenser
  import vm_pkg::*;
#(
  parameter int CREDIT_W = 6
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                load,
  input  logic [CREDIT_W-1:0] load_val,
  output logic [1:0]          change,
  output logic                busy,
  output logic                done
);

  logic [CREDIT_W-1:0] remain;
  logic [CREDIT_W-1:0] src;
  logic [1:0]          coin;

  function automatic logic [1:0] largest_coin(input logic [CREDIT_W-1:0] r);
    if (r >= CREDIT_W'(4))      return COIN_20;
    else if (r >= CREDIT_W'(2)) return COIN_10;
    else if (r >= CREDIT_W'(1)) return COIN_5;
    else                        return COIN_NONE;
  endfunction

  // Pick the amount being paid from (fresh load or what is left) and its coin.
  always_comb begin
    src  = load ? load_val : remain;
    coin = largest_coin(src);
  end

  // Register the coin for this cycle and the amount still owed afterwards.
  always_ff @(posedge clk) begin
    if (rst) begin
      remain <= '0;
      change <= COIN_NONE;
      busy   <= 1'b0;
    end else begin
      change <= coin;
      busy   <= (coin != COIN_NONE);
      remain <= src - CREDIT_W'(coin_units(coin));
    end
  end

  // Last coin of the sequence is on the output this cycle.
  assign done = busy && (remain == '0);

endmodule

// File: rtl/vending_machine_multi.sv
// Multi-product vending machine: credit accumulation, per-item stock,
// purchase decode and refund control. Change is paid out by the
// vm_change_dispenser sub-module.
module vending_machine_multi
  import vm_pkg::*;
#(
  parameter int NUM_ITEMS  = 4,
  parameter int SEL_W      = 2,
  parameter int CREDIT_W   = 6,
  parameter int MAX_CREDIT = 40,
  parameter int STOCK_W    = 4,
  parameter int STOCK_INIT = 10,
  parameter logic [NUM_ITEMS*CREDIT_W-1:0] PRICE_LIST = {6'd10, 6'd5, 6'd4, 6'd3}
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [1:0]           in,
  input  logic [SEL_W-1:0]     sel,
  input  logic                 buy,
  input  logic                 cancel,
  input  logic                 restock,
  output logic                 out,
  output logic [SEL_W-1:0]     item_id,
  output logic [1:0]           change,
  output logic                 coin_reject,
  output logic                 err_soldout,
  output logic                 err_funds,
  output logic                 busy,
  output logic [CREDIT_W-1:0]  credit,
  output logic [NUM_ITEMS-1:0] sold_out
);

  state_t              state;
  logic [STOCK_W-1:0]  stock [NUM_ITEMS];

  logic                sel_ok;
  logic [CREDIT_W-1:0] price;
  logic [STOCK_W-1:0]  sel_stock;
  logic [CREDIT_W:0]   credit_sum;
  logic                coin_fits;
  logic                buy_ok;
  logic                chg_load;
  logic [CREDIT_W-1:0] chg_val;
  logic                chg_done;

  // Decode the selected item, coin cap test and whether change must start.
  always_comb begin
    sel_ok    = (int'(sel) < NUM_ITEMS);
    price     = '0;
    sel_stock = '0;
    for (int i = 0; i < NUM_ITEMS; i++) begin
      if (sel == SEL_W'(i)) begin
        price     = PRICE_LIST[i*CREDIT_W +: CREDIT_W];
        sel_stock = stock[i];
      end
    end
    // One extra bit so the cap compare can never wrap.
    credit_sum = {1'b0, credit} + (CREDIT_W+1)'(coin_units(in));
    coin_fits  = (credit_sum <= (CREDIT_W+1)'(MAX_CREDIT));
    buy_ok     = sel_ok && (sel_stock != '0) && (credit >= price);
    chg_load   = 1'b0;
    chg_val    = credit;
    if (state == ST_ACCEPT) begin
      if (cancel) begin
        chg_load = (credit != '0);
      end else if (buy && buy_ok) begin
        chg_val  = credit - price;
        chg_load = (credit != price);
      end
    end
  end

  // Main FSM: credit, stock and single-cycle status pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_ACCEPT;
      credit      <= '0;
      out         <= 1'b0;
      item_id     <= '0;
      coin_reject <= 1'b0;
      err_soldout <= 1'b0;
      err_funds   <= 1'b0;
      for (int i = 0; i < NUM_ITEMS; i++) stock[i] <= STOCK_W'(STOCK_INIT);
    end else begin
      out         <= 1'b0;
      coin_reject <= 1'b0;
      err_soldout <= 1'b0;
      err_funds   <= 1'b0;
      case (state)
        ST_ACCEPT: begin
          if (cancel) begin
            if (credit != '0) credit <= '0;
          end else if (buy) begin
            if (sel_ok) begin
              if (sel_stock == '0) begin
                err_soldout <= 1'b1;
              end else if (credit < price) begin
                err_funds <= 1'b1;
              end else begin
                out     <= 1'b1;
                item_id <= sel;
                credit  <= '0;
                for (int i = 0; i < NUM_ITEMS; i++)
                  if (sel == SEL_W'(i)) stock[i] <= sel_stock - STOCK_W'(1);
              end
            end
          end else if (restock && sel_ok) begin
            for (int i = 0; i < NUM_ITEMS; i++)
              if (sel == SEL_W'(i)) stock[i] <= STOCK_W'(STOCK_INIT);
          end
          // Coins are only taken on an otherwise idle cycle and under the cap.
          if (in != COIN_NONE) begin
            if (!buy && !cancel && coin_fits) credit <= credit_sum[CREDIT_W-1:0];
            else                              coin_reject <= 1'b1;
          end
          if (chg_load) state <= ST_CHANGE;
        end
        ST_CHANGE: begin
          if (in != COIN_NONE) coin_reject <= 1'b1;
          if (chg_done) state <= ST_ACCEPT;
        end
        default: state <= ST_ACCEPT;
      endcase
    end
  end

  // Sold-out flags follow the stock registers one cycle later.
  always_ff @(posedge clk) begin
    if (rst) begin
      sold_out <= '0;
    end else begin
      for (int i = 0; i < NUM_ITEMS; i++) sold_out[i] <= (stock[i] == '0);
    end
  end

  vm_change_dispenser #(
    .CREDIT_W (CREDIT_W)
  ) u_change (
    .clk      (clk),
    .rst      (rst),
    .load     (chg_load),
    .load_val (chg_val),
    .change   (change),
    .busy     (busy),
    .done     (chg_done)
  );

endmodule
